// File: rtl/sf_pkg.sv
// Shared constants and helpers for the sf_filter moving-average smoother.
// Optional macro SF_ROUND_EN (used in sf_filter) selects round-half-up scaling.
package sf_pkg;

   localparam int unsigned DefDataW    = 16;
   localparam int unsigned DefLog2Taps = 2;

   // Widest intermediate the saturate helper handles
   localparam int unsigned MaxW = 64;

   function automatic int unsigned sum_w(input int unsigned data_w,
                                         input int unsigned log2_taps);
      return data_w + log2_taps;
   endfunction

   // Clamp a sign-extended value to the signed range of data_w bits.
   function automatic logic signed [MaxW-1:0] saturate(input logic signed [MaxW-1:0] value,
                                                       input int unsigned data_w);
      logic signed [MaxW-1:0] max_val;
      logic signed [MaxW-1:0] min_val;
      logic signed [MaxW-1:0] result;
      max_val = (MaxW'(1) << (data_w - 1)) - MaxW'(1);
      min_val = -max_val - MaxW'(1);
      if (value > max_val) begin
         result = max_val;
      end else if (value < min_val) begin
         result = min_val;
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/sf_delay_line.sv
// TAPS-deep signed shift register with synchronous clear; exposes the entry
// that drops out on the next shift.
module sf_delay_line #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic signed [WIDTH-1:0] data_in,
   output logic signed [WIDTH-1:0] oldest
);

   logic signed [WIDTH-1:0] taps_q [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            taps_q[i] <= '0;
         end
      end else begin
         taps_q[0] <= data_in;
         for (int i = 1; i < DEPTH; i++) begin
            taps_q[i] <= taps_q[i-1];
         end
      end
   end

   assign oldest = taps_q[DEPTH-1];

endmodule

// File: rtl/sf_filter.sv
// Streaming moving-average filter over the last 2^LOG2_TAPS signed samples.
// Define SF_ROUND_EN for round-half-up scaling; default build truncates (floor).
module sf_filter
   import sf_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned LOG2_TAPS = DefLog2Taps
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] data_in,
   output logic signed [DATA_W-1:0] data_out
);

   localparam int unsigned Taps = 1 << LOG2_TAPS;
   localparam int unsigned SumW = sum_w(DATA_W, LOG2_TAPS);

   logic signed [DATA_W-1:0] oldest;
   logic signed [SumW-1:0]   sum_q;
   logic signed [SumW-1:0]   sum_d;
   logic signed [SumW-1:0]   in_ext;
   logic signed [SumW-1:0]   old_ext;
   logic signed [SumW:0]     scaled_pre;
   logic signed [SumW:0]     scaled;
   logic signed [MaxW-1:0]   wide;
   logic signed [DATA_W-1:0] data_out_d;

   sf_delay_line #(
      .WIDTH (DATA_W),
      .DEPTH (Taps)
   ) u_delay_line (
      .clk     (clk),
      .clr     (rst),
      .data_in (data_in),
      .oldest  (oldest)
   );

`ifdef SF_ROUND_EN
   localparam logic signed [SumW:0] RoundBias = (SumW+1)'(1) << (LOG2_TAPS - 1);
`endif

   always_comb begin
      in_ext  = {{LOG2_TAPS{data_in[DATA_W-1]}}, data_in};
      old_ext = {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest};
      sum_d   = sum_q + in_ext - old_ext;

      // One extra bit keeps the rounding bias from overflowing
      scaled_pre = {sum_d[SumW-1], sum_d};
`ifdef SF_ROUND_EN
      scaled_pre = scaled_pre + RoundBias;
`endif
      scaled     = scaled_pre >>> LOG2_TAPS;
      wide       = {{(MaxW-SumW-1){scaled[SumW]}}, scaled};
      data_out_d = DATA_W'(saturate(wide, DATA_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q    <= '0;
         data_out <= '0;
      end else begin
         sum_q    <= sum_d;
         data_out <= data_out_d;
      end
   end

endmodule

// File: tb/tb_sf_filter.sv
// Scoreboard bench for sf_filter: expectations queued at drive time, popped
// and compared one edge later.
module tb_sf_filter;

   localparam int unsigned DataW   = 16;
   localparam int unsigned Log2Tap = 2;
   localparam int          Taps    = 1 << Log2Tap;
   localparam int          OutMax  = (1 << (DataW - 1)) - 1;
   localparam int          OutMin  = -(1 << (DataW - 1));

   typedef struct {
      string tag;
      int    value;
   } exp_t;

   logic                    clk;
   logic                    rst;
   logic signed [DataW-1:0] data_in;
   logic signed [DataW-1:0] data_out;

   exp_t exp_q[$];
   int   hist[$];
   int   n_checks;
   int   n_errors;

   sf_filter #(
      .DATA_W    (DataW),
      .LOG2_TAPS (Log2Tap)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Reference: direct window sum, then scale and clamp.
   function automatic int model_out();
      longint s;
      longint m;
      s = 0;
      foreach (hist[i]) s += hist[i];
`ifdef SF_ROUND_EN
      s += Taps / 2;
`endif
      m = s >>> Log2Tap;
      if (m > OutMax) m = OutMax;
      if (m < OutMin) m = OutMin;
      return int'(m);
   endfunction

   task automatic clear_hist();
      hist.delete();
      for (int i = 0; i < Taps; i++) hist.push_back(0);
   endtask

   // use_tbl=1 queues the hand-derived value instead of the model's.
   task automatic drive(input logic r, input int x, input string tag,
                        input bit use_tbl, input int tbl);
      exp_t e;
      @(negedge clk);
      rst     = r;
      data_in = x[DataW-1:0];
      if (r) begin
         clear_hist();
      end else begin
         hist.push_front(x);
         void'(hist.pop_back());
      end
      e.tag   = tag;
      e.value = r ? 0 : (use_tbl ? tbl : model_out());
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, int'(data_out), e.value);
      end
   end

   initial begin
      int ramp_in[6];
      int ramp_exp[6];
      int neg_exp[5];
      int x;

      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      data_in  = 16'sd500;
      clear_hist();

      ramp_in  = '{100, 200, 150, 250, 180, 120};
`ifdef SF_ROUND_EN
      ramp_exp = '{25, 75, 113, 175, 195, 175};
      neg_exp  = '{0, 0, 0, 0, 0};
`else
      ramp_exp = '{25, 75, 112, 175, 195, 175};
      neg_exp  = '{-1, -1, -1, -1, 0};
`endif

      // Reset held with nonzero input, then zeros
      drive(1'b1, 500, "reset0", 1'b1, 0);
      drive(1'b1, 500, "reset1", 1'b1, 0);
      drive(1'b0, 0, "zero_after_reset", 1'b1, 0);
      drive(1'b0, 0, "zero_after_reset", 1'b1, 0);

      drive(1'b1, 0, "reset", 1'b1, 0);
      for (int i = 0; i < 6; i++) drive(1'b0, ramp_in[i], "ramp", 1'b1, ramp_exp[i]);

      // Stale history must be discarded
      drive(1'b1, 777, "mid_reset", 1'b1, 0);
      drive(1'b0, 400, "after_mid_reset", 1'b1, 100);

      drive(1'b1, 0, "reset", 1'b1, 0);
      drive(1'b0, -1, "neg_floor", 1'b1, neg_exp[0]);
      for (int i = 1; i < 5; i++) drive(1'b0, 0, "neg_floor", 1'b1, neg_exp[i]);

      drive(1'b1, 0, "reset", 1'b1, 0);
      for (int i = 0; i < 3; i++) drive(1'b0, 32767, "max_fill", 1'b0, 0);
      drive(1'b0, 32767, "max_reach", 1'b1, 32767);
      for (int i = 0; i < 3; i++) drive(1'b0, -32768, "min_fill", 1'b0, 0);
      drive(1'b0, -32768, "min_reach", 1'b1, -32768);
      drive(1'b0, -32768, "min_hold", 1'b1, -32768);

      drive(1'b1, 0, "reset", 1'b1, 0);
      for (int i = 0; i < 10; i++) begin
         if (i < 3) drive(1'b0, 1234, "steady_fill", 1'b0, 0);
         else       drive(1'b0, 1234, "steady", 1'b1, 1234);
      end

      // Random full-range stream with an occasional reset
      for (int i = 0; i < 60; i++) begin
         x = int'($urandom_range(0, 65535)) - 32768;
         if (i == 30) drive(1'b1, x, "rand_reset", 1'b1, 0);
         else         drive(1'b0, x, "random", 1'b0, 0);
      end

      @(negedge clk);
      @(posedge clk);
      #2;
      check("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sf_filter.md
Name: sf_filter

Overview:
- Streaming moving-average (smoothing) filter on signed two's-complement samples.
- Accepts one new sample on every clock and produces a registered average of the most recent 2^LOG2_TAPS samples.
- Sits inline in the sample datapath and has no handshake; the stream is continuous, one sample per clock.

Parameters:
- DATA_W, 16: width of data_in and data_out (signed).
- LOG2_TAPS, 2: log2 of the window length. TAPS = 2^LOG2_TAPS. Legal range is 1..6.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- data_in, input, DATA_W: signed input sample, captured on every rising edge while rst=0.
- data_out, output, DATA_W: signed filtered output, registered.

Behaviour:
- Reset: when rst=1 at a rising edge, all TAPS delay-line entries, the running sum and data_out become 0. data_in is ignored that cycle.
- Reset mid-stream: history is discarded completely. The filter restarts as if it had seen zeros.
- Delay line: a shift register of TAPS signed DATA_W entries. On each non-reset edge, data_in enters at the head and the oldest entry is dropped.
- Running sum:
  - Signed, SUM_W = DATA_W+LOG2_TAPS bits.
  - Each edge: sum_next = sum + data_in - oldest, where oldest is the entry being dropped (zero during fill after reset).
  - Sign-extend all operands to SUM_W before adding.
  - This arithmetic never overflows SUM_W.
- Output:
  - data_out_next = sum_next >>> LOG2_TAPS (arithmetic shift, floor toward -inf), registered on the same edge.
  - Latency: a sample presented before edge k is included in data_out immediately after edge k (1 cycle).
- Fill behaviour: for the first TAPS-1 samples after reset, missing history counts as 0. No special scaling is applied; the output ramps up.
- Range: the average always fits DATA_W. The implementation must still clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] after any rounding, as a guard.
- Steady constant input x: after TAPS edges, data_out = x exactly.
- No valid/ready signals. Every non-reset edge consumes a sample.

Optional Feature:
- Macro: SF_ROUND_EN.
- Defined: data_out = (sum_next + 2^(LOG2_TAPS-1)) >>> LOG2_TAPS, i.e. round half up. Compute at SUM_W+1 bits, then clamp to DATA_W.
- Undefined: truncation (floor) as above.
- Reset, latency and delay line are identical in both builds.

Decomposition:
- Package sf_pkg holds:
  - default DATA_W/LOG2_TAPS constants;
  - a SUM_W helper function;
  - a saturate function (SUM_W+1 to DATA_W).
- One sub-module, sf_delay_line: a parameterised TAPS-deep signed shift register with synchronous clear, exposing the oldest entry.
- The top level holds the accumulator, the scaling/rounding logic and the output register.

Test Plan (defaults DATA_W=16, LOG2_TAPS=2, truncation unless stated):
- Reset: hold rst=1 for 2 edges with data_in=500 -> data_out=0. Release, then apply data_in=0 -> data_out stays 0.
- Ramp-up: after reset, feed 100,200,150,250,180,120 on successive edges -> data_out after each edge = 25, 75, 112, 175, 195, 175. With SF_ROUND_EN, the third value is 113.
- Negative/floor: after reset, a single -1 then zeros -> data_out = -1, -1, -1, -1, then 0. With SF_ROUND_EN -> all 0.
- Extremes: 4 samples of 32767 -> data_out reaches 32767. Then 4 samples of -32768 -> reaches -32768 with no wrap. Check in both builds.
- Mid-stream reset: after the ramp-up sequence, assert rst for 1 edge, then feed 400 -> data_out = 100 (stale history discarded).
- Steady-state: constant 1234 for 10 edges -> data_out = 1234 from the 4th edge onward.
